fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch front end: owns the program counter, issues sequential word requests to a one-cycle-latency instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. Downstream stages pull from it over a valid/ready handshake. A redirect port (branch/jump/trap target) flushes the buffer and restarts fetch at the new address. It replaces the free-running PC → PC+4 → imem chain in the CPU top.

## Interface
- XLEN, 32, address/PC width (instructions fixed at 32 bits)
- DEPTH, 4, fetch-buffer entries; power of two, ≥ 2
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset (XLEN wide, bits [1:0] = 0)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  fetch request this cycle
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_rsp_valid  in  1  response for the request issued the previous cycle
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  one-cycle pulse: restart fetch
- redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored (treated as 0)
- out_valid  out  1  buffer head holds an instruction
- out_ready  in  1  consumer accepts the head this cycle
- out_pc  out  XLEN  PC of the head instruction
- out_instr  out  32  head instruction word
- fetch_count  out  32  number of instructions accepted downstream (wraps)

## Operation
- State: fetch_pc (XLEN), inflight (1 bit), FIFO storage with wr/rd pointers and count (0..DEPTH), fetch_count.
- imem_req_addr = fetch_pc at all times.
- pop = out_valid & out_ready.
- Request issue: `imem_req_valid = !redirect_valid & (count + inflight - pop < DEPTH)`.
  - On issue, fetch_pc ← fetch_pc + 4, wrapping modulo 2^XLEN.
  - inflight ← imem_req_valid.
- Response handling:
  - When imem_rsp_valid & inflight & !redirect_valid, push {pc of that request, imem_rsp_data}.
  - The request PC is held in a one-entry register captured at issue.
  - imem_rsp_valid with inflight = 0 is ignored.
- The credit rule guarantees a push never hits a full FIFO. Simultaneous push and pop leaves count unchanged.
- Redirect (redirect_valid = 1):
  - FIFO flushed: count ← 0, pointers reset.
  - Any response arriving this cycle is discarded.
  - No request is issued this cycle.
  - inflight ← 0.
  - fetch_pc ← {redirect_pc[XLEN-1:2], 2'b00}.
  - A pop in the same cycle still counts toward fetch_count, but the flush overrides the pointer update.
- fetch_count increments by 1 on every pop, wrapping at 2^32.
- Reset, asynchronous, usable mid-operation; all state is cleared immediately:
  - fetch_pc = RESET_VECTOR, inflight = 0, count = 0, fetch_count = 0.
  - Outputs: imem_req_valid = 0, out_valid = 0, out_pc = 0, out_instr = 0, imem_req_addr = RESET_VECTOR.
  - An in-flight memory response arriving after reset release is ignored, because inflight = 0.

## Timing
- Memory contract: a request in cycle t returns its data in cycle t+1.
- First cycle after reset release (cycle 0): request RESET_VECTOR.
  - Push at the end of cycle 1.
  - out_valid = 1 in cycle 2 with out_pc = RESET_VECTOR.
- Redirect in cycle t:
  - First request to the target in t+1.
  - out_valid with out_pc = target in t+3.
  - out_valid = 0 in t+1 and t+2.
- Throughput: with out_ready held at 1, one instruction per cycle in steady state for any DEPTH ≥ 2.
- Backpressure: with out_ready = 0, requests stop once count + inflight = DEPTH.
  - No instruction is lost or duplicated.
  - Fetch resumes in the same cycle as the first pop.
- out_pc and out_instr are stable while out_valid = 1 and out_ready = 0; they are driven from FIFO storage.

## Test plan
- Reset, then release; imem returns addr ^ 32'hA5A5_0000, out_ready = 1 → out stream PC 0x0, 0x4, 0x8, … from cycle 2, one per cycle, instr = PC ^ 0xA5A5_0000.
- DEPTH = 4, out_ready = 0 for 10 cycles → exactly 4 requests issued and out_pc stays 0x0. Then out_ready = 1 → 0x0..0x1C delivered with no gap or duplicate.
- Redirect to 0x0000_1002 while the FIFO holds 3 entries and a request is in flight → entries and the in-flight response are dropped. Next request is 0x1000, and it appears at out 3 cycles after the redirect.
- Redirect asserted in the same cycle as a pop → fetch_count increments by 1 and the FIFO is empty the next cycle.
- Redirect to 0xFFFF_FFF8 → out_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
- Assert reset mid-stream with out_valid = 1 and a request in flight → outputs clear immediately. After release, fetch restarts at RESET_VECTOR, the stale response is ignored, and fetch_count = 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues word requests to a one-cycle
// instruction memory and buffers returned instructions with their PCs for downstream.
module fetch_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [31:0]     fetch_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = CW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic            pop_c;
  logic            push_c;
  logic [OW-1:0]   credit_c;
  logic [XLEN-1:0] target_c;

  assign imem_req_addr = fetch_pc;
  assign out_valid     = (count != '0);
  assign out_pc        = pc_mem[rd_ptr];
  assign out_instr     = instr_mem[rd_ptr];

  // Occupancy the buffer will see once the in-flight word lands and the head leaves.
  always_comb begin
    pop_c          = out_valid & out_ready;
    push_c         = imem_rsp_valid & inflight & ~redirect_valid;
    credit_c       = OW'(count) + OW'(inflight) - OW'(pop_c);
    imem_req_valid = reset & ~redirect_valid & (credit_c < OW'(DEPTH));
    target_c       = redirect_pc & ~XLEN'(3);
  end

  // PC, in-flight tracking, pointers and the accepted-instruction counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_VECTOR;
      req_pc      <= RESET_VECTOR;
      inflight    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      fetch_count <= '0;
    end else begin
      fetch_count <= fetch_count + 32'(pop_c);
      if (redirect_valid) begin
        fetch_pc <= target_c;
        inflight <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        inflight <= imem_req_valid;
        if (imem_req_valid) begin
          fetch_pc <= fetch_pc + XLEN'(4);
          req_pc   <= fetch_pc;
        end
        if (push_c) wr_ptr <= wr_ptr + AW'(1);
        if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push_c) - CW'(pop_c);
      end
    end
  end

  // Buffer storage; cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (push_c) begin
      pc_mem[wr_ptr]    <= req_pc;
      instr_mem[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised and directed bench for fetch_unit against a queue-based fetch model.
module tb_fetch_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic            clk;
  logic            reset;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [31:0]     fetch_count;

  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fetch_count    (fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Memory side: remembers last cycle's request to answer it this cycle.
  logic        mem_pend;
  logic [31:0] mem_addr;

  // Values sampled in the most recent cycle.
  logic        s_req, s_ov;
  logic [31:0] s_addr, s_pc, s_instr, s_fc;

  // Reference model: buffered (pc, instr) pairs, outstanding request, next PC, pop count.
  logic [31:0] m_qpc[$];
  logic [31:0] m_qins[$];
  logic        m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_pc;
  logic [31:0] m_fc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_qpc.delete();
    m_qins.delete();
    m_pend    = 1'b0;
    m_pend_pc = 32'h0;
    m_pc      = 32'h0;
    m_fc      = 32'h0;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic cycle(input logic redir, input logic [31:0] tgt, input logic rdy);
    logic m_ov, pop, exp_req;
    int   occ;
    redirect_valid = redir;
    redirect_pc    = tgt;
    out_ready      = rdy;
    if (mem_pend) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_addr ^ 32'hA5A5_0000;
    end else begin
      imem_rsp_valid = ($urandom_range(0, 3) == 0);
      imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    s_req   = imem_req_valid;
    s_addr  = imem_req_addr;
    s_ov    = out_valid;
    s_pc    = out_pc;
    s_instr = out_instr;
    s_fc    = fetch_count;

    m_ov    = (m_qpc.size() != 0);
    pop     = m_ov && rdy;
    occ     = m_qpc.size() + int'(m_pend) - int'(pop);
    exp_req = !redir && (occ < int'(DEPTH));
    chk("out_valid", 32'(s_ov), 32'(m_ov));
    if (m_ov) begin
      chk("out_pc", s_pc, m_qpc[0]);
      chk("out_instr", s_instr, m_qins[0]);
    end
    chk("req_valid", 32'(s_req), 32'(exp_req));
    chk("req_addr", s_addr, m_pc);
    chk("fetch_count", s_fc, m_fc);

    if (pop) m_fc = m_fc + 32'd1;
    if (redir) begin
      m_qpc.delete();
      m_qins.delete();
      m_pend = 1'b0;
      m_pc   = tgt & ~32'd3;
    end else begin
      if (pop) begin
        void'(m_qpc.pop_front());
        void'(m_qins.pop_front());
      end
      if (imem_rsp_valid && m_pend) begin
        m_qpc.push_back(m_pend_pc);
        m_qins.push_back(imem_rsp_data);
      end
      m_pend = exp_req;
      if (exp_req) begin
        m_pend_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end
    end

    mem_pend = imem_req_valid;
    mem_addr = imem_req_addr;
    @(posedge clk);
    #1;
  endtask

  // Clean reset: held across two edges, released just after a rising edge.
  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    mem_pend       = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Reset pulsed inside a cycle; the memory still answers the pre-reset request afterwards.
  task automatic mid_reset();
    reset = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_fetch_count", fetch_count, 32'h0);
    model_reset();
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int nreq;
    logic [31:0] fc_t;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    mem_pend       = 1'b0;
    #2;
    chk("init_out_valid", 32'(out_valid), 32'h0);
    chk("init_req_valid", 32'(imem_req_valid), 32'h0);
    chk("init_out_pc", out_pc, 32'h0);
    chk("init_fetch_count", fetch_count, 32'h0);

    // Streaming with the consumer always ready.
    do_reset();
    cycle(1'b0, 32'h0, 1'b1);
    chk("c0_req_valid", 32'(s_req), 32'h1);
    chk("c0_req_addr", s_addr, 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    chk("c1_out_valid", 32'(s_ov), 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    chk("c2_out_valid", 32'(s_ov), 32'h1);
    chk("c2_out_pc", s_pc, 32'h0);
    chk("c2_out_instr", s_instr, 32'hA5A5_0000);
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b0, 32'h0, 1'b1);
      chk("stream_pc", s_pc, 32'(k * 4));
    end

    // Backpressure: exactly DEPTH requests, then a gap-free drain.
    do_reset();
    nreq = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 32'h0, 1'b0);
      nreq += int'(s_req);
    end
    chk("bp_req_count", 32'(nreq), 32'd4);
    chk("bp_hold_pc", s_pc, 32'h0);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 32'h0, 1'b1);
      chk("bp_drain_valid", 32'(s_ov), 32'h1);
      chk("bp_drain_pc", s_pc, 32'(k * 4));
    end

    // Redirect with three buffered entries and one request outstanding.
    do_reset();
    repeat (4) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h0000_1002, 1'b0);
    chk("redir_t_req", 32'(s_req), 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    chk("redir_t1_req", 32'(s_req), 32'h1);
    chk("redir_t1_addr", s_addr, 32'h0000_1000);
    chk("redir_t1_ov", 32'(s_ov), 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    chk("redir_t2_ov", 32'(s_ov), 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    chk("redir_t3_ov", 32'(s_ov), 32'h1);
    chk("redir_t3_pc", s_pc, 32'h0000_1000);
    chk("redir_t3_instr", s_instr, 32'hA5A5_1000);

    // Redirect coinciding with a pop.
    repeat (2) cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b1, 32'h0000_2000, 1'b1);
    chk("rpop_t_ov", 32'(s_ov), 32'h1);
    fc_t = s_fc;
    cycle(1'b0, 32'h0, 1'b1);
    chk("rpop_fc", s_fc, fc_t + 32'd1);
    chk("rpop_empty", 32'(s_ov), 32'h0);

    // Address wrap at the top of the space.
    cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (2) cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    chk("wrap_pc0", s_pc, 32'hFFFF_FFF8);
    cycle(1'b0, 32'h0, 1'b1);
    chk("wrap_pc1", s_pc, 32'hFFFF_FFFC);
    cycle(1'b0, 32'h0, 1'b1);
    chk("wrap_pc2", s_pc, 32'h0000_0000);

    // Reset mid-stream with data buffered and a request outstanding.
    cycle(1'b0, 32'h0, 1'b1);
    chk("mid_pre_ov", 32'(s_ov), 32'h1);
    chk("mid_pre_req", 32'(s_req), 32'h1);
    mid_reset();
    cycle(1'b0, 32'h0, 1'b1);
    chk("mid_c0_addr", s_addr, 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    chk("mid_c1_ov", 32'(s_ov), 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    chk("mid_c2_pc", s_pc, 32'h0);
    chk("mid_c2_fc", s_fc, 32'h0);

    // Random traffic: sporadic stalls, redirects and occasional resets.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 499) == 0) mid_reset();
      cycle(($urandom_range(0, 19) == 0), $urandom, ($urandom_range(0, 9) < 7));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
